servo_scan_ctrl: RTL and testbench
==================================

Name: servo_scan_ctrl

Overview:
Sequencer that drives the servo PWM generator through a fixed scan: left, center, right. At each position it waits a settle time in PWM frames, then requests one measurement from the range-sensor block and waits for its acknowledge. It owns the PWM generator's Enable, dutty and period inputs and sits between the top-level navigation FSM and the PWM instance.

Parameters:
PERIOD, 20'd999, PWM period value driven to the generator; one frame = PERIOD+1 clk cycles
DUTY_LEFT, 12'd50, duty value for the left position
DUTY_CENTER, 12'd75, duty value for the center position
DUTY_RIGHT, 12'd100, duty value for the right position
SETTLE_FRAMES, 8'd25, number of full frames held before a measurement request (must be >= 1)
ACK_TIMEOUT, 16'd50000, maximum clk cycles to wait for meas_ack

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous active-high reset
start  input  1  level; sampled only in IDLE, begins a scan
pwm_enable  output  1  to PWM Enable
pwm_dutty  output  12  to PWM dutty
pwm_period  output  20  to PWM period; constant PERIOD
meas_req  output  1  measurement request, held until acknowledged
meas_ack  input  1  single-cycle pulse from the sensor block
pos_idx  output  2  current position: 0=left, 1=center, 2=right
sample_valid  output  1  one-cycle pulse when the measurement for pos_idx completes
timeout_err  output  1  sticky; set on ack timeout, cleared by start or rst
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the scan finishes

Behaviour:
- Reset values: pwm_enable=0, pwm_dutty=DUTY_CENTER, pwm_period=PERIOD, meas_req=0, pos_idx=0, sample_valid=0, timeout_err=0, busy=0, done=0. FSM goes to IDLE and all counters clear.
- Reset mid-scan aborts immediately: outputs take their reset values on the next edge, no done pulse, and a pending meas_req drops.
- States: IDLE, SETTLE, MEASURE, NEXT, FINISH.
- IDLE: when start=1, go to SETTLE next cycle with pos_idx=0, pwm_dutty=DUTY_LEFT, pwm_enable=1, timeout_err cleared, frame counters zeroed.
- SETTLE:
  - cyc_cnt counts 0..PERIOD and wraps to 0, matching the generator's frame.
  - frame_cnt increments on each wrap.
  - When frame_cnt reaches SETTLE_FRAMES at the wrap, go to MEASURE and assert meas_req in the same cycle.
  - Settle time is exactly SETTLE_FRAMES*(PERIOD+1) cycles from entry.
- MEASURE:
  - meas_req stays high and pwm_enable stays 1 (servo holds position).
  - If meas_ack=1: drop meas_req, pulse sample_valid for one cycle, go to NEXT.
  - If the wait counter reaches ACK_TIMEOUT with no ack: set timeout_err, drop meas_req, go to NEXT with no sample_valid.
  - If ack and timeout occur on the same cycle, the ack wins.
  - meas_ack outside MEASURE is ignored.
- NEXT (1 cycle):
  - If pos_idx<2: increment pos_idx, load the next duty, clear counters, go to SETTLE.
  - If pos_idx=2: go to FINISH.
- FINISH (1 cycle): pulse done, pwm_enable=0, pos_idx returns to 0, go to IDLE.
- start held high in FINISH or IDLE restarts the scan on the cycle after IDLE is re-entered. start is ignored while busy.
- pwm_dutty changes only on NEXT or IDLE→SETTLE edges, never mid-frame except at those transitions.
- Counters: cyc_cnt 20 bits, frame_cnt 8 bits, ack counter 16 bits, all unsigned; none may overflow given legal parameters.

Optional Feature:
SERVO_SCAN_RETURN_EN:
- Defined: FINISH is replaced by a RETURN state. It drives pwm_dutty=DUTY_CENTER with pwm_enable=1 for SETTLE_FRAMES frames, then pulses done, sets pwm_enable=0 and goes to IDLE. There is no measurement in RETURN, pos_idx=1 during it, and busy stays high.
- Undefined: behaviour is as described above, with servo power cut immediately at the right position.

Test Plan:
- rst high for 2 cycles, then low → all outputs equal their reset values; busy=0.
- PERIOD=9, SETTLE_FRAMES=2: start pulse → meas_req rises exactly 20 cycles after the pwm_enable rise with pwm_dutty=50. Ack after 3 cycles → sample_valid for 1 cycle, pos_idx 0→1.
- Full scan with immediate acks → pwm_dutty sequence 50, 75, 100; three sample_valid pulses; done pulses once; pwm_enable=0 afterwards.
- ACK_TIMEOUT=16, never ack at center → timeout_err=1 after 16 wait cycles, no sample_valid for pos 1, scan continues to right, done asserted. The next start clears timeout_err.
- rst asserted while in MEASURE at pos 1 → next cycle meas_req=0, pwm_enable=0, pos_idx=0, no done. A new start rescans from left.
- With SERVO_SCAN_RETURN_EN defined: after right-position ack → pwm_dutty=75 for 2*(PERIOD+1) cycles, then done, then pwm_enable=0.

Source files
------------

// File: rtl/servo_scan_ctrl.sv
// Servo scan sequencer: sweeps left/center/right, settles for whole PWM frames, then
// requests one range measurement per position. Define SERVO_SCAN_RETURN_EN to park at center afterwards.
module servo_scan_ctrl #(
    parameter logic [19:0] PERIOD        = 20'd999,
    parameter logic [11:0] DUTY_LEFT     = 12'd50,
    parameter logic [11:0] DUTY_CENTER   = 12'd75,
    parameter logic [11:0] DUTY_RIGHT    = 12'd100,
    parameter logic [7:0]  SETTLE_FRAMES = 8'd25,
    parameter logic [15:0] ACK_TIMEOUT   = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        pwm_enable,
    output logic [11:0] pwm_dutty,
    output logic [19:0] pwm_period,
    output logic        meas_req,
    input  logic        meas_ack,
    output logic [1:0]  pos_idx,
    output logic        sample_valid,
    output logic        timeout_err,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        NEXT,
`ifdef SERVO_SCAN_RETURN_EN
        RETURN
`else
        FINISH
`endif
    } state_t;

    state_t      state;
    logic [19:0] cyc_cnt;
    logic [7:0]  frame_cnt;
    logic [15:0] ack_cnt;
    logic        frame_end;
    logic        settle_end;

    assign pwm_period = PERIOD;

    // settle_end marks the final cycle of the last settle frame
    always_comb begin
        frame_end  = (cyc_cnt == PERIOD);
        settle_end = frame_end && (frame_cnt == SETTLE_FRAMES - 8'd1);
    end

    function automatic logic [11:0] duty_of(input logic [1:0] p);
        case (p)
            2'd0:    return DUTY_LEFT;
            2'd1:    return DUTY_CENTER;
            default: return DUTY_RIGHT;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cyc_cnt      <= '0;
            frame_cnt    <= '0;
            ack_cnt      <= '0;
            pwm_enable   <= 1'b0;
            pwm_dutty    <= DUTY_CENTER;
            meas_req     <= 1'b0;
            pos_idx      <= 2'd0;
            sample_valid <= 1'b0;
            timeout_err  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SETTLE;
                        pos_idx     <= 2'd0;
                        pwm_dutty   <= DUTY_LEFT;
                        pwm_enable  <= 1'b1;
                        timeout_err <= 1'b0;
                        cyc_cnt     <= '0;
                        frame_cnt   <= '0;
                        busy        <= 1'b1;
                    end
                end

                SETTLE: begin
                    if (frame_end) begin
                        cyc_cnt <= '0;
                        if (settle_end) begin
                            frame_cnt <= '0;
                            ack_cnt   <= '0;
                            meas_req  <= 1'b1;
                            state     <= MEASURE;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 20'd1;
                    end
                end

                MEASURE: begin
                    // an ack arriving on the timeout cycle still counts as a sample
                    if (meas_ack) begin
                        meas_req     <= 1'b0;
                        sample_valid <= 1'b1;
                        state        <= NEXT;
                    end else if (ack_cnt == ACK_TIMEOUT - 16'd1) begin
                        meas_req    <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= NEXT;
                    end else begin
                        ack_cnt <= ack_cnt + 16'd1;
                    end
                end

                NEXT: begin
                    cyc_cnt   <= '0;
                    frame_cnt <= '0;
                    if (pos_idx != 2'd2) begin
                        pos_idx   <= pos_idx + 2'd1;
                        pwm_dutty <= duty_of(pos_idx + 2'd1);
                        state     <= SETTLE;
                    end else begin
`ifdef SERVO_SCAN_RETURN_EN
                        pos_idx   <= 2'd1;
                        pwm_dutty <= DUTY_CENTER;
                        state     <= RETURN;
`else
                        pos_idx    <= 2'd0;
                        pwm_enable <= 1'b0;
                        done       <= 1'b1;
                        state      <= FINISH;
`endif
                    end
                end

`ifdef SERVO_SCAN_RETURN_EN
                RETURN: begin
                    if (frame_end) begin
                        cyc_cnt <= '0;
                        if (settle_end) begin
                            frame_cnt  <= '0;
                            pos_idx    <= 2'd0;
                            pwm_enable <= 1'b0;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 20'd1;
                    end
                end
`else
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_scan_ctrl.sv
// Bench for servo_scan_ctrl: timeline model of a scan computed from per-position ack plans,
// checked every cycle, plus literal checks on latency, duty order, timeouts and reset abort.
module tb_servo_scan_ctrl;
    localparam int P  = 9;
    localparam int SF = 2;
    localparam int AT = 16;
    localparam int S  = SF * (P + 1);
    localparam int DL = 50, DC = 75, DR = 100;
`ifdef SERVO_SCAN_RETURN_EN
    localparam bit RET = 1'b1;
`else
    localparam bit RET = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, meas_ack = 1'b0;
    logic        pwm_enable, meas_req, sample_valid, timeout_err, busy, done;
    logic [11:0] pwm_dutty;
    logic [19:0] pwm_period;
    logic [1:0]  pos_idx;

    always #5 clk = ~clk;

    servo_scan_ctrl #(
        .PERIOD(20'd9), .DUTY_LEFT(12'd50), .DUTY_CENTER(12'd75), .DUTY_RIGHT(12'd100),
        .SETTLE_FRAMES(8'd2), .ACK_TIMEOUT(16'd16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pwm_enable(pwm_enable), .pwm_dutty(pwm_dutty),
        .pwm_period(pwm_period), .meas_req(meas_req), .meas_ack(meas_ack), .pos_idx(pos_idx),
        .sample_valid(sample_valid), .timeout_err(timeout_err), .busy(busy), .done(done)
    );

    int n_cmp = 0, n_err = 0, cyc = 0;

    // model: a scan is a timeline t=0.. from the first settle cycle; m_d[p] is the ack
    // delay (in measure cycles) planned for position p, -1 meaning never acked
    bit m_scan = 0, m_terr = 0, m_done_now = 0;
    int m_t = 0, m_idle_duty = DC;
    int m_d[3], plan_d[3];

    int  e_en, e_duty, e_req, e_pos, e_sv, e_terr, e_busy, e_done;
    bit  e_win, e_ack_due;

    // per-scan observations for literal checks
    int en_rise_cyc, first_req_cyc, duty_at_req, first_sv_cyc, pos_first_sv, pos_after_sv;
    int sv_cnt, done_cnt, ret_cnt;
    int req_cycles[3];
    int duty_q[$];
    bit prev_en, seen_right;

    function automatic int wlen(int p);
        return (m_d[p] < 0) ? AT : m_d[p] + 1;
    endfunction

    function automatic int tstart(int p);
        int s = 0;
        for (int q = 0; q < p; q++) s += S + wlen(q) + 1;
        return s;
    endfunction

    function automatic int duty(int p);
        return (p == 0) ? DL : (p == 1) ? DC : DR;
    endfunction

    function automatic int last_t();
        return RET ? tstart(3) + S - 1 : tstart(3);
    endfunction

    function automatic bit any_to();
        return (m_d[0] < 0) || (m_d[1] < 0) || (m_d[2] < 0);
    endfunction

    task automatic calc_exp();
        int p, r, w;
        e_en = 0; e_duty = m_idle_duty; e_req = 0; e_pos = 0; e_sv = 0;
        e_terr = m_terr; e_busy = 0; e_done = m_done_now; e_win = 0; e_ack_due = 0;
        if (m_scan) begin
            e_busy = 1; e_done = 0;
            if (m_t < tstart(3)) begin
                p = 0;
                while (p < 2 && m_t >= tstart(p + 1)) p++;
                r = m_t - tstart(p);
                w = wlen(p);
                e_en = 1; e_pos = p; e_duty = duty(p);
                e_win = (r >= S) && (r < S + w);
                e_req = e_win;
                e_ack_due = e_win && (m_d[p] >= 0) && (r == S + m_d[p]);
                e_sv = (r == S + w) && (m_d[p] >= 0);
                e_terr = 0;
                for (int q = 0; q < p; q++) if (m_d[q] < 0) e_terr = 1;
                if (m_d[p] < 0 && r == S + w) e_terr = 1;
            end else begin
                e_terr = any_to();
                if (RET) begin
                    e_en = 1; e_pos = 1; e_duty = DC;
                end else begin
                    e_en = 0; e_pos = 0; e_duty = DR; e_done = 1;
                end
            end
        end
    endtask

    task automatic advance(input bit st, input bit rs);
        if (rs) begin
            m_scan = 0; m_terr = 0; m_idle_duty = DC; m_done_now = 0;
        end else if (!m_scan) begin
            m_done_now = 0;
            if (st) begin
                m_scan = 1; m_t = 0; m_d = plan_d;
            end
        end else if (m_t == last_t()) begin
            m_scan = 0; m_terr = any_to();
            m_idle_duty = RET ? DC : DR;
            m_done_now = RET;
        end else begin
            m_t++;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clr_stats();
        en_rise_cyc = -1; first_req_cyc = -1; duty_at_req = -1; first_sv_cyc = -1;
        pos_first_sv = -1; pos_after_sv = -1; sv_cnt = 0; done_cnt = 0; ret_cnt = 0;
        req_cycles = '{0, 0, 0}; duty_q.delete(); seen_right = 0;
    endtask

    // the single per-cycle compare against the model, plus observation bookkeeping
    task automatic compare();
        calc_exp();
        chk("pwm_enable", pwm_enable, e_en);
        chk("pwm_dutty", pwm_dutty, e_duty);
        chk("pwm_period", pwm_period, P);
        chk("meas_req", meas_req, e_req);
        chk("pos_idx", pos_idx, e_pos);
        chk("sample_valid", sample_valid, e_sv);
        chk("timeout_err", timeout_err, e_terr);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        if (pwm_enable && !prev_en && en_rise_cyc < 0) en_rise_cyc = cyc;
        if (meas_req && first_req_cyc < 0) begin
            first_req_cyc = cyc; duty_at_req = pwm_dutty;
        end
        if (cyc == first_sv_cyc + 1 && first_sv_cyc >= 0) pos_after_sv = pos_idx;
        if (sample_valid && first_sv_cyc < 0) begin
            first_sv_cyc = cyc; pos_first_sv = pos_idx;
        end
        if (meas_req) req_cycles[pos_idx] = req_cycles[pos_idx] + 1;
        sv_cnt += sample_valid;
        done_cnt += done;
        if (pwm_enable && pos_idx == 2) seen_right = 1;
        if (seen_right && pwm_enable && pwm_dutty == 12'd75) ret_cnt++;
        if (pwm_enable && (duty_q.size() == 0 || duty_q[$] != int'(pwm_dutty)))
            duty_q.push_back(int'(pwm_dutty));
        prev_en = pwm_enable;
    endtask

    task automatic step(input bit st, input bit rs, input bit spur);
        calc_exp();
        start = st;
        rst   = rs;
        meas_ack = e_ack_due ? 1'b1 : (spur && !e_win && $urandom_range(0, 5) == 0);
        @(posedge clk);
        advance(st, rs);
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic run_idle(input bit spur);
        int n = 0;
        while (m_scan && n < 2000) begin
            step(0, 0, spur);
            n++;
        end
        if (m_scan) begin
            n_cmp++; n_err++;
            $display("FAIL run_idle: scan still active after %0d cycles", n);
        end
        step(0, 0, 0);
    endtask

    initial begin
        int n;
        bit restarted;
        prev_en = 0;
        clr_stats();
        plan_d = '{0, 0, 0};
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        chk("rst_enable", pwm_enable, 0);
        chk("rst_dutty", pwm_dutty, 75);
        chk("rst_period", pwm_period, 9);
        chk("rst_req", meas_req, 0);
        chk("rst_pos", pos_idx, 0);
        chk("rst_sv", sample_valid, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // first scan: ack after 3 cycles at left, immediate elsewhere
        clr_stats();
        plan_d = '{3, 0, 0};
        step(1, 0, 0);
        run_idle(0);
        chk("A_req_latency", first_req_cyc - en_rise_cyc, 20);
        chk("A_req_duty", duty_at_req, 50);
        chk("A_sv_latency", first_sv_cyc - first_req_cyc, 4);
        chk("A_sv_pos", pos_first_sv, 0);
        chk("A_pos_after_sv", pos_after_sv, 1);
        chk("A_duty_count", duty_q.size(), RET ? 4 : 3);
        chk("A_duty0", duty_q[0], 50);
        chk("A_duty1", duty_q[1], 75);
        chk("A_duty2", duty_q[2], 100);
        chk("A_sv_count", sv_cnt, 3);
        chk("A_done_count", done_cnt, 1);
        chk("A_enable_after", pwm_enable, 0);
`ifdef SERVO_SCAN_RETURN_EN
        chk("A_return_cycles", ret_cnt, 20);
`endif

        // center never acks: timeout, scan continues
        clr_stats();
        plan_d = '{0, -1, 5};
        step(1, 0, 0);
        run_idle(0);
        chk("B_sv_count", sv_cnt, 2);
        chk("B_req_cycles_center", req_cycles[1], 16);
        chk("B_done_count", done_cnt, 1);
        chk("B_terr", timeout_err, 1);
        plan_d = '{0, 0, 0};
        step(1, 0, 0);
        chk("B_terr_cleared", timeout_err, 0);
        run_idle(0);

        // reset while measuring at center
        plan_d = '{0, -1, 0};
        step(1, 0, 0);
        n = 0;
        calc_exp();
        while (!(e_win && e_pos == 1) && n < 500) begin
            step(0, 0, 0);
            calc_exp();
            n++;
        end
        chk("C_reached_measure", meas_req, 1);
        clr_stats();
        step(0, 1, 0);
        chk("C_req", meas_req, 0);
        chk("C_enable", pwm_enable, 0);
        chk("C_pos", pos_idx, 0);
        chk("C_done", done, 0);
        step(0, 0, 0);
        plan_d = '{1, 2, 0};
        step(1, 0, 0);
        chk("C_restart_duty", pwm_dutty, 50);
        run_idle(0);
        chk("C_done_count", done_cnt, 1);

        // start held high the whole time: back-to-back scans
        plan_d = '{0, 0, 0};
        step(1, 0, 0);
        n = 0;
        restarted = 0;
        while (!restarted && n < 2000) begin
            if (!m_scan) restarted = 1;
            step(1, 0, 0);
            n++;
        end
        chk("D_restarted", m_scan && busy, 1);
        run_idle(0);

        // random plans, spurious acks, start while busy, rare resets
        for (int k = 0; k < 40; k++) begin
            for (int p = 0; p < 3; p++)
                plan_d[p] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, AT - 1));
            n = $urandom_range(0, 5);
            for (int g = 0; g < n; g++) step(0, 0, 1);
            step(1, 0, 1);
            n = 0;
            while (m_scan && n < 2000) begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 499) == 0, 1);
                n++;
            end
            if (m_scan) begin
                n_cmp++; n_err++;
                $display("FAIL random_bound: scan %0d did not end", k);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
